// File: rtl/wave_period_meter.sv
// -----------------------------------------------------------------------------
// wave_period_meter
//
// Measures an 8-bit offset-binary waveform. It finds rising midscale crossings
// with hysteresis and, for each complete cycle, reports the period (counted in
// samples, not clocks) and the peak and trough samples of that cycle.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   sample_en   sample strobe; wave is consumed only while high
//   wave        unsigned 8-bit sample, offset binary
//   period      samples in the last complete cycle
//   peak        maximum sample of the last complete cycle
//   trough      minimum sample of the last complete cycle
//   meas_valid  one-clock pulse when period/peak/trough update
//   locked      high once a full cycle has been measured; cleared on timeout
// -----------------------------------------------------------------------------
module wave_period_meter #(
   parameter int MID  = 127,
   parameter int HYST = 8,
   parameter int PW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_en,
   input  logic [7:0]    wave,
   output logic [PW-1:0] period,
   output logic [7:0]    peak,
   output logic [7:0]    trough,
   output logic          meas_valid,
   output logic          locked
);

   localparam logic [1:0] ACQ_LOW  = 2'd0;
   localparam logic [1:0] ACQ_HIGH = 2'd1;
   localparam logic [1:0] RUN_LOW  = 2'd2;
   localparam logic [1:0] RUN_HIGH = 2'd3;

   // Thresholds are held in 9 bits so MID+HYST can never wrap.
   localparam logic [8:0] LOW_TH  = 9'(MID - HYST);
   localparam logic [8:0] HIGH_TH = 9'(MID + HYST);

   // Counter value one below saturation: incrementing past it means the
   // counter has reached 2^PW-1 without a completing crossing.
   localparam logic [PW-1:0] CNT_LAST = {{(PW-1){1'b1}}, 1'b0};

   logic [1:0]    state_reg,  state_next;
   logic [PW-1:0] cnt_reg,    cnt_next;
   logic [7:0]    run_max_reg, run_max_next;
   logic [7:0]    run_min_reg, run_min_next;
   logic [PW-1:0] period_reg, period_next;
   logic [7:0]    peak_reg,   peak_next;
   logic [7:0]    trough_reg, trough_next;
   logic          valid_reg,  valid_next;
   logic          locked_reg, locked_next;

   logic is_low;
   logic is_high;

   assign is_low  = ({1'b0, wave} <= LOW_TH);
   assign is_high = ({1'b0, wave} >= HIGH_TH);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      run_max_next = run_max_reg;
      run_min_next = run_min_reg;
      period_next  = period_reg;
      peak_next    = peak_reg;
      trough_next  = trough_reg;
      valid_next   = 1'b0;
      locked_next  = locked_reg;

      if (sample_en) begin
         case (state_reg)
            ACQ_LOW: begin
               if (is_low) state_next = ACQ_HIGH;
            end
            ACQ_HIGH: begin
               // First crossing only opens a cycle; nothing to report yet.
               if (is_high) begin
                  cnt_next     = '0;
                  run_max_next = wave;
                  run_min_next = wave;
                  state_next   = RUN_LOW;
               end
            end
            default: begin
               if (state_reg == RUN_HIGH && is_high) begin
                  // Completing crossing: publish the closed cycle, then the
                  // crossing sample seeds the new cycle's extremes.
                  period_next  = cnt_reg + PW'(1);
                  peak_next    = run_max_reg;
                  trough_next  = run_min_reg;
                  valid_next   = 1'b1;
                  locked_next  = 1'b1;
                  cnt_next     = '0;
                  run_max_next = wave;
                  run_min_next = wave;
                  state_next   = RUN_LOW;
               end else if (cnt_reg == CNT_LAST) begin
                  // Cycle too long to measure: drop lock, keep last results.
                  cnt_next    = cnt_reg + PW'(1);
                  locked_next = 1'b0;
                  state_next  = ACQ_LOW;
               end else begin
                  cnt_next = cnt_reg + PW'(1);
                  if (wave > run_max_reg) run_max_next = wave;
                  if (wave < run_min_reg) run_min_next = wave;
                  if (state_reg == RUN_LOW && is_low) state_next = RUN_HIGH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ACQ_LOW;
         cnt_reg     <= '0;
         run_max_reg <= 8'd0;
         run_min_reg <= 8'd255;
         period_reg  <= '0;
         peak_reg    <= 8'd0;
         trough_reg  <= 8'd255;
         valid_reg   <= 1'b0;
         locked_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         run_max_reg <= run_max_next;
         run_min_reg <= run_min_next;
         period_reg  <= period_next;
         peak_reg    <= peak_next;
         trough_reg  <= trough_next;
         valid_reg   <= valid_next;
         locked_reg  <= locked_next;
      end
   end

   assign period     = period_reg;
   assign peak       = peak_reg;
   assign trough     = trough_reg;
   assign meas_valid = valid_reg;
   assign locked     = locked_reg;

endmodule

// File: tb/tb_wave_period_meter.sv
// -----------------------------------------------------------------------------
// Testbench for wave_period_meter. Two instances: dut0 (PW=16) and dut8 (PW=8,
// used for the timeout case). Stimulus pushes the expected measurement into a
// per-instance queue just before the crossing sample is driven; a monitor per
// instance pops and compares whenever meas_valid is seen.
// -----------------------------------------------------------------------------
module tb_wave_period_meter;

   typedef struct {
      int p_lo;
      int p_hi;
      int pk_lo;
      int pk_hi;
      int tr_lo;
      int tr_hi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en0 = 1'b0;
   logic [7:0]  wave0 = 8'd0;
   logic        en1 = 1'b0;
   logic [7:0]  wave1 = 8'd0;

   logic [15:0] period0;
   logic [7:0]  peak0, trough0;
   logic        mv0, locked0;
   logic [7:0]  period1;
   logic [7:0]  peak1, trough1;
   logic        mv1, locked1;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   always #5 clk = ~clk;

   wave_period_meter #(.MID(127), .HYST(8), .PW(16)) dut0 (
      .clk(clk), .rst(rst), .sample_en(en0), .wave(wave0),
      .period(period0), .peak(peak0), .trough(trough0),
      .meas_valid(mv0), .locked(locked0)
   );

   wave_period_meter #(.MID(127), .HYST(8), .PW(8)) dut8 (
      .clk(clk), .rst(rst), .sample_en(en1), .wave(wave1),
      .period(period1), .peak(peak1), .trough(trough1),
      .meas_valid(mv1), .locked(locked1)
   );

   task automatic chk(input string nm, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
      end else begin
         $display("ok   %s: %0d (t=%0t)", nm, act, $time);
      end
   endtask

   task automatic push(input int sel, input int plo, input int phi,
                       input int pklo, input int pkhi, input int trlo, input int trhi);
      exp_t e;
      e.p_lo = plo;  e.p_hi = phi;
      e.pk_lo = pklo; e.pk_hi = pkhi;
      e.tr_lo = trlo; e.tr_hi = trhi;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   // One sample on the selected instance, then gap idle clocks (wave=0 while
   // idle, which would be a low sample if it were wrongly consumed).
   task automatic send(input int sel, input int w, input int gap);
      @(negedge clk);
      if (sel == 0) begin en0 = 1'b1; wave0 = 8'(w); end
      else          begin en1 = 1'b1; wave1 = 8'(w); end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         en0 = 1'b0; en1 = 1'b0; wave0 = 8'd0; wave1 = 8'd0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en0 = 1'b0; en1 = 1'b0;
      end
   endtask

   // Square wave: 10 samples at 200, 10 at 50 per cycle. Cycles before 'skip'
   // produce no measurement; cycle 'skip' reports p0, later cycles 20.
   task automatic square(input int sel, input int ncyc, input int skip,
                         input int p0, input int gap);
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 10; i++) begin
            if (i == 0 && c >= skip) begin
               if (c == skip) push(sel, p0, p0, 200, 200, 50, 50);
               else           push(sel, 20, 20, 200, 200, 50, 50);
            end
            send(sel, 200, gap);
         end
         for (int i = 0; i < 10; i++) send(sel, 50, gap);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mv0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_meas0: period %0d peak %0d trough %0d, required no pulse (t=%0t)",
                     period0, peak0, trough0, $time);
         end else begin
            e0 = q0.pop_front();
            chk("period0", int'(period0), e0.p_lo, e0.p_hi);
            chk("peak0",   int'(peak0),   e0.pk_lo, e0.pk_hi);
            chk("trough0", int'(trough0), e0.tr_lo, e0.tr_hi);
            chk("locked0_at_meas", int'(locked0), 1, 1);
            chk("strobe0_aligned", int'(en0), 1, 1);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (mv1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_meas8: period %0d peak %0d trough %0d, required no pulse (t=%0t)",
                     period1, peak1, trough1, $time);
         end else begin
            e1 = q1.pop_front();
            chk("period8", int'(period1), e1.p_lo, e1.p_hi);
            chk("peak8",   int'(peak1),   e1.pk_lo, e1.pk_hi);
            chk("trough8", int'(trough1), e1.tr_lo, e1.tr_hi);
            chk("locked8_at_meas", int'(locked1), 1, 1);
         end
      end
   end

   initial begin
      int s, c, w;

      // Reset state of both instances
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_period0", int'(period0), 0, 0);
      chk("rst_peak0",   int'(peak0),   0, 0);
      chk("rst_trough0", int'(trough0), 255, 255);
      chk("rst_mv0",     int'(mv0),     0, 0);
      chk("rst_locked0", int'(locked0), 0, 0);
      chk("rst_period8", int'(period1), 0, 0);
      chk("rst_trough8", int'(trough1), 255, 255);
      rst = 1'b0;

      // 1: continuous square wave; first report on the third rising edge
      square(0, 4, 2, 20, 0);
      idle(1);
      chk("t1_locked0", int'(locked0), 1, 1);

      // 2: strobe one clock in three; period still counts samples
      square(0, 3, 0, 20, 2);

      // 3: in-band dither holds everything, then the long cycle is reported
      for (int i = 0; i < 1000; i++) send(0, 120 + ((i * 7) % 15), 0);
      idle(1);
      chk("t3_hold_period0", int'(period0), 20, 20);
      chk("t3_hold_peak0",   int'(peak0),   200, 200);
      chk("t3_hold_trough0", int'(trough0), 50, 50);
      chk("t3_hold_locked0", int'(locked0), 1, 1);
      square(0, 2, 0, 1020, 0);

      // 6: asynchronous reset in RUN_HIGH
      push(0, 20, 20, 200, 200, 50, 50);
      for (int i = 0; i < 10; i++) send(0, 200, 0);
      for (int i = 0; i < 5; i++) send(0, 50, 0);
      @(negedge clk);
      en0 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_period0", int'(period0), 0, 0);
      chk("arst_peak0",   int'(peak0),   0, 0);
      chk("arst_trough0", int'(trough0), 255, 255);
      chk("arst_locked0", int'(locked0), 0, 0);
      chk("arst_mv0",     int'(mv0),     0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) send(0, 50, 0);
      square(0, 3, 1, 20, 0);

      // 4: PW=8 timeout after 255 samples without a crossing
      square(1, 3, 2, 20, 0);
      push(1, 20, 20, 200, 200, 50, 50);
      send(1, 200, 0);
      for (int i = 0; i < 254; i++) send(1, 200, 0);
      idle(1);
      chk("t4_locked8_before", int'(locked1), 1, 1);
      send(1, 200, 0);
      idle(1);
      chk("t4_locked8_after", int'(locked1), 0, 0);
      chk("t4_period8_held",  int'(period1), 20, 20);
      square(1, 3, 2, 20, 0);
      idle(1);
      chk("t4_relocked8", int'(locked1), 1, 1);

      // 5: integer sin/cos oscillator (step 1/64), fresh reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) push(0, 401, 403, 240, 255, 0, 14);
      s = 0;
      c = 30000;
      for (int i = 0; i < 1800; i++) begin
         w = (s >>> 8) + 128;
         if (w < 0)   w = 0;
         if (w > 255) w = 255;
         send(0, w, 0);
         s = s + (c >>> 6);
         c = c - (s >>> 6);
      end

      idle(3);
      chk("q0_drained", q0.size(), 0, 0);
      chk("q8_drained", q1.size(), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
